// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: digit width, FSM state
// encoding and the digit-counter width helper.
package digit_serial_adder_pkg;

  // Bits consumed per clock by the carry-look-ahead slice.
  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Width of the digit counter: clog2 of the digit count, never below 1 bit
  // so that a single-digit adder still has a legal counter vector.
  function automatic int cnt_width(input int width);
    int n;
    n = $clog2(width / DIGIT_W);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/digit_serial_adder_cla_digit_slice.sv
// cla_digit_slice: purely combinational 2-bit carry-look-ahead adder slice.
// Per-bit generate/propagate feed a look-ahead carry chain; sum = P ^ carry.
module cla_digit_slice
  import digit_serial_adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W-1:0] g;
  logic [DIGIT_W-1:0] p;
  logic [DIGIT_W-1:0] c;   // carry into each bit of the digit

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_W; gi++) begin : g_gp
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Look-ahead carries expressed directly from G/P and the incoming carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign cout = g[1] | (p[1] & c[1]);

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands one 2-bit digit per clock,
// LSB digit first, reusing a single cla_digit_slice with a registered carry.
// Optional macro DIGIT_SERIAL_OVERFLOW_EN adds a signed-overflow output OVF.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef DIGIT_SERIAL_OVERFLOW_EN
  ,
  output logic             OVF
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / DIGIT_W - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  logic [DIGIT_W-1:0] slice_sum;
  logic               slice_cout;
  logic [WIDTH+DIGIT_W-1:0] sum_shift;
  logic               accept;

  cla_digit_slice u_slice (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .cin  (carry_q),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // New digit enters the accumulator from the top; written this way so it
  // stays legal even when WIDTH equals one digit.
  assign sum_shift = {slice_sum, sum_q} >> DIGIT_W;

  // A start is honoured whenever no digits are in flight (IDLE or FIN).
  assign accept = start && (state_q != RUN);

  // Next-state and datapath update for the whole block.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      RUN: begin
        sum_d   = sum_shift[WIDTH-1:0];
        carry_d = slice_cout;
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
          cout_d  = slice_cout;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
          // Carry into the MSB recovered from the final sum MSB and operand MSBs.
          ovf_d   = (a_msb_q ^ b_msb_q ^ slice_sum[DIGIT_W-1]) ^ slice_cout;
`endif
        end
      end
      default: begin
        // IDLE and FIN behave identically apart from FIN always leaving.
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          cnt_d   = '0;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // BUSY and DONE are pure state decodes, so reset clears them immediately.
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign SUM  = sum_q;
  assign COUT = cout_q;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
  assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder at WIDTH=16.
// Honours DIGIT_SERIAL_OVERFLOW_EN to also check OVF.
module tb_digit_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef DIGIT_SERIAL_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  digit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .CIN   (cin),
    .BUSY  (busy),
    .DONE  (done),
    .SUM   (sum),
    .COUT  (cout)
`ifdef DIGIT_SERIAL_OVERFLOW_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition from idle, time the BUSY window and check the result.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    int busy_cnt;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = '1; b = '1; cin = 1'b1;   // operands must already be captured
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n, 8);
    check_val({tag, "_busycyc"}, busy_cnt, 8);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_busy_fin"}, busy, 0);
    check_val({tag, "_sum"}, sum, es);
    check_val({tag, "_cout"}, cout, ec);
`ifdef DIGIT_SERIAL_OVERFLOW_EN
    check_val({tag, "_ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    tick();
    check_val({tag, "_done_drop"}, done, 0);
    check_val({tag, "_sum_hold"}, sum, es);
    $display("op %s: 0x%04h + 0x%04h + %0d -> sum=0x%04h cout=%0d", tag, av, bv, cv, sum, cout);
  endtask

  initial begin : main
    int dcount;
    int t1, t2;
    logic [W-1:0] s1, s2;
    logic c1, c2;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_cout", cout, 0);
`ifdef DIGIT_SERIAL_OVERFLOW_EN
    check_val("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    run_op("ff_p1",   16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sovf",    16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("mixed",   16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);

    // start pulsed during RUN must be ignored
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    check_val("ign_busy", busy, 1);
    tick();
    start = 1'b0;
    dcount = 0;
    s1 = '0; c1 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        dcount++;
        s1 = sum;
        c1 = cout;
      end
      tick();
    end
    check_val("ign_dones", dcount, 1);
    check_val("ign_sum", s1, 16'h2345);
    check_val("ign_cout", c1, 0);
    $display("op ignore: 0x1234 + 0x1111 -> sum=0x%04h dones=%0d", s1, dcount);

    // reset mid-operation
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mrst_busy", busy, 0);
    check_val("mrst_sum", sum, 0);
    check_val("mrst_cout", cout, 0);
    check_val("mrst_done", done, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcount++;
      tick();
    end
    check_val("mrst_nodone", dcount, 0);
    $display("op midreset: busy=%0d sum=0x%04h dones_after=%0d", busy, sum, dcount);
    run_op("after_rst", 16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0);

    // back-to-back with start held high
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h8000; b = 16'h8000;
    dcount = 0;
    t1 = -1; t2 = -1;
    s1 = '0; s2 = '1; c1 = 1'b1; c2 = 1'b0;
    for (int i = 0; i < 30 && dcount < 2; i++) begin
      if (done) begin
        if (dcount == 0) begin
          t1 = i; s1 = sum; c1 = cout;
        end else begin
          t2 = i; s2 = sum; c2 = cout;
        end
        dcount++;
      end
      if (dcount < 2) tick();
    end
    start = 1'b0;
    check_val("b2b_dones", dcount, 2);
    check_val("b2b_gap", t2 - t1, 9);
    check_val("b2b_sum1", s1, 16'h0002);
    check_val("b2b_cout1", c1, 0);
    check_val("b2b_sum2", s2, 16'h0000);
    check_val("b2b_cout2", c2, 1);
`ifdef DIGIT_SERIAL_OVERFLOW_EN
    check_val("b2b_ovf2", ovf, 1);
`endif
    $display("op b2b: sum1=0x%04h cout1=%0d sum2=0x%04h cout2=%0d gap=%0d", s1, c1, s2, c2, t2 - t1);
    for (int i = 0; i < 12; i++) tick();
    check_val("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Sequential wrapper that adds two WIDTH-bit operands one 2-bit digit per clock, LSB digit first.
- A single 2-bit carry-look-ahead slice is reused every cycle; the carry is registered between digits.
- Sits between the operand source and the result consumer: captures operands on a start pulse, streams digits through the slice, assembles SUM/COUT, and signals completion.
- Trades latency (WIDTH/2 cycles) for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be even and >= 2.

Ports:
- clk    input   1      system clock, rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request to begin an addition; sampled only when not busy
- A      input   WIDTH  operand A; captured on accepted start
- B      input   WIDTH  operand B; captured on accepted start
- CIN    input   1      carry-in; captured on accepted start
- BUSY   output  1      high while digits are being processed
- DONE   output  1      one-cycle pulse when SUM/COUT become valid
- SUM    output  WIDTH  result, held stable until the next accepted start
- COUT   output  1      carry out of the MSB digit, held with SUM

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: BUSY=0, DONE=0, SUM=0, COUT=0, carry register=0, digit counter=0, state=IDLE.
- States: IDLE, RUN, FIN.
- IDLE --start--> RUN.
  - On that edge: latch A, B into shift registers and CIN into the carry register; clear the counter; set BUSY=1.
- RUN, each edge:
  - Slice inputs: low 2 bits of A/B shift regs plus the carry register.
  - Slice 2-bit sum shifts into the SUM accumulator from the top (accumulator shifts right by 2).
  - Slice carry-out goes to the carry register; A/B shift regs shift right by 2; counter increments.
- RUN exit: on the edge where counter == WIDTH/2-1, go to FIN.
  - SUM takes its final value; COUT = slice carry-out; BUSY=0; DONE=1.
- FIN lasts exactly one cycle. DONE=1 only in FIN. Next edge: FIN -> IDLE, DONE=0.
- Latency: start sampled at edge 0; DONE high in the cycle after edge WIDTH/2; results valid from that cycle.
- Back-to-back: start sampled in FIN is accepted (FIN -> RUN) and behaves as from IDLE; DONE still deasserts on that edge.
- start while BUSY=1 (RUN): ignored; no operand re-capture; current operation unaffected.
- SUM/COUT are not cleared by a new start; they change only during RUN shifting.
  - Consumers use SUM/COUT only when DONE=1, or in IDLE after DONE.
- Reset mid-operation (any state): all registers return to reset values on that edge; no DONE pulse is produced.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1); unsigned; no saturation.
- A, B, CIN may change freely except on the accepted-start edge.

Optional Feature:
- Macro: DIGIT_SERIAL_OVERFLOW_EN
- Defined:
  - Adds output port OVF, 1 bit, reset 0.
  - Signed two's-complement overflow = carry into MSB XOR COUT, where carry into MSB = A[WIDTH-1]^B[WIDTH-1]^SUM[WIDTH-1] using the latched operand MSBs.
  - Updated on the same edge as final SUM; held with SUM.
- Undefined: no OVF port, no MSB latch; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - DIGIT_W = 2
  - state encoding constants: IDLE=2'd0, RUN=2'd1, FIN=2'd2
  - counter-width function (clog2 of WIDTH/2)
- One sub-module: cla_digit_slice.
  - Purely combinational 2-bit carry-look-ahead slice: generate/propagate per bit, carry C1 = G0 | P0&Cin, COUT = G1 | P1&C1, sum bits P^carry.
  - Instantiated once by digit_serial_adder.
  - Rest of the block is the FSM, counter, and shift registers.

Test Plan (WIDTH=16):
- A=0x00FF, B=0x0001, CIN=0, start pulse -> BUSY high for 8 cycles; DONE one cycle; SUM=0x0100; COUT=0.
- A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1 (full carry ripple across all 8 digits); with macro, OVF=0.
- A=0x7FFF, B=0x0000, CIN=1 -> SUM=0x8000, COUT=0; with macro, OVF=1.
- Start 0x1234+0x1111; at RUN cycle 3 pulse start with A=0xFFFF, B=0xFFFF -> ignored; SUM=0x2345; single DONE.
- Start 0xAAAA+0x5555 CIN=1; assert rst at RUN cycle 4 -> next cycle BUSY=0, SUM=0, COUT=0, no DONE. Then 0x0003+0x0001 -> SUM=0x0004.
- Back-to-back: start held high continuously with 0x0001+0x0001, then 0x8000+0x8000 accepted in FIN -> DONE pulses 9 cycles apart; SUM=0x0002 then SUM=0x0000, COUT=1.
